// File: rtl/bar_height_loader.sv
// Bar height loader: on a Nios load request, read every bar height out of
// the height RAM into a shadow bank. The shadow bank is then copied to the
// visible bank that drives the VGA controller, either at the next frame
// boundary or as soon as the sweep finishes.
module bar_height_loader #(
    parameter int NUM_BARS        = 20,
    parameter int HEIGHT_W        = 6,
    parameter int ADDR_W          = 6,
    parameter int RD_LATENCY      = 3,
    parameter int COMMIT_ON_VSYNC = 1
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         data_back,
    input  logic                         VGA_VS,
    input  logic [HEIGHT_W-1:0]          rd_q,
    output logic [ADDR_W-1:0]            rd_addr,
    output logic                         ready,
    output logic [NUM_BARS*HEIGHT_W-1:0] heights,
    output logic                         frame_updated,
    output logic [7:0]                   drop_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        DRAIN   = 2'd2,
        PENDING = 2'd3
    } state_t;

    localparam int                BANK_W    = NUM_BARS * HEIGHT_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BARS - 1);

    state_t                         state_q, state_d;
    logic                           db_q, db_d;
    logic                           vs_q, vs_d;
    logic [ADDR_W-1:0]              rd_addr_q, rd_addr_d;
    logic [RD_LATENCY-1:0]          pipe_valid_q, pipe_valid_d;
    logic [RD_LATENCY-1:0][ADDR_W-1:0] pipe_tag_q, pipe_tag_d;
    logic [BANK_W-1:0]              shadow_q, shadow_d;
    logic [BANK_W-1:0]              heights_q, heights_d;
    logic                           frame_updated_q, frame_updated_d;
    logic [7:0]                     drop_count_q, drop_count_d;
    logic                           req;
    logic                           fb;
    logic                           pipe_empty;
    logic                           commit;

    // Rising edge of the load request, falling edge of vsync (frame boundary)
    always_comb begin
        db_d       = data_back;
        vs_d       = VGA_VS;
        req        = data_back & ~db_q;
        fb         = ~VGA_VS & vs_q;
        pipe_empty = ~|pipe_valid_q;
    end

    // Next-state logic of the load sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = ISSUE;
            ISSUE:   if (rd_addr_q == LAST_ADDR) state_d = DRAIN;
            DRAIN:   if (pipe_empty) state_d = (COMMIT_ON_VSYNC != 0) ? PENDING : IDLE;
            PENDING: if (fb) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state: ready flag and the commit strobe
    always_comb begin
        ready  = (state_q == IDLE);
        commit = 1'b0;
        if ((state_q == DRAIN) && pipe_empty && (COMMIT_ON_VSYNC == 0)) commit = 1'b1;
        if ((state_q == PENDING) && fb) commit = 1'b1;
    end

    // Address sweep, read-latency token pipeline, shadow capture, commit and drop counting
    always_comb begin
        rd_addr_d = '0;
        if ((state_q == ISSUE) && (rd_addr_q != LAST_ADDR)) rd_addr_d = rd_addr_q + ADDR_W'(1);

        pipe_valid_d    = '0;
        pipe_tag_d      = '0;
        pipe_valid_d[0] = (state_q == ISSUE);
        pipe_tag_d[0]   = rd_addr_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_tag_d[i]   = pipe_tag_q[i-1];
        end

        shadow_d = shadow_q;
        for (int i = 0; i < NUM_BARS; i++) begin
            if (pipe_valid_q[RD_LATENCY-1] && (pipe_tag_q[RD_LATENCY-1] == ADDR_W'(i)))
                shadow_d[i*HEIGHT_W +: HEIGHT_W] = rd_q;
        end

        heights_d       = commit ? shadow_q : heights_q;
        frame_updated_d = commit;

        drop_count_d = drop_count_q;
        if (req && (state_q != IDLE) && (drop_count_q != 8'hFF))
            drop_count_d = drop_count_q + 8'd1;
    end

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Datapath registers; reset abandons any sweep in flight and blanks the bars
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            db_q            <= 1'b1;
            vs_q            <= 1'b0;
            rd_addr_q       <= '0;
            pipe_valid_q    <= '0;
            pipe_tag_q      <= '0;
            shadow_q        <= '0;
            heights_q       <= '0;
            frame_updated_q <= 1'b0;
            drop_count_q    <= '0;
        end else begin
            db_q            <= db_d;
            vs_q            <= vs_d;
            rd_addr_q       <= rd_addr_d;
            pipe_valid_q    <= pipe_valid_d;
            pipe_tag_q      <= pipe_tag_d;
            shadow_q        <= shadow_d;
            heights_q       <= heights_d;
            frame_updated_q <= frame_updated_d;
            drop_count_q    <= drop_count_d;
        end
    end

    assign rd_addr       = rd_addr_q;
    assign heights       = heights_q;
    assign frame_updated = frame_updated_q;
    assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_bar_height_loader.sv
// Testbench for bar_height_loader: a frame-synchronised instance plus an
// immediate-commit instance, both fed by a behavioural RAM with fixed read
// latency. A scoreboard holds expected commits; a monitor checks each one.
module tb_bar_height_loader;

    localparam int NB  = 20;
    localparam int HW  = 6;
    localparam int AW  = 6;
    localparam int LAT = 3;
    localparam int BW  = NB * HW;
    // Cycles from the accepted request to the first cycle a commit can happen:
    // the load itself (1 + NB + LAT) plus the cycle that sees the pipeline empty.
    localparam int COMMIT_DELAY = 1 + NB + LAT + 1;

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b1;
    logic          data_back = 1'b1;
    logic          VGA_VS = 1'b1;
    logic          data_back2 = 1'b0;
    logic          VGA_VS2 = 1'b1;
    logic [HW-1:0] rd_q, rd_q2;
    logic [AW-1:0] rd_addr, rd_addr2;
    logic          ready, ready2;
    logic [BW-1:0] heights, heights2;
    logic          frame_updated, frame_updated2;
    logic [7:0]    drop_count, drop_count2;

    logic [HW-1:0] ram [64];
    logic [AW-1:0] apipe  [LAT];
    logic [AW-1:0] apipe2 [LAT];

    int cycle_count = 0;
    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic          prev_db = 1'b1;
    logic          prev_vs = 1'b0;
    logic          mdl_busy = 1'b0;
    int            mdl_start = 0;
    logic [BW-1:0] mdl_snap = '0;
    int            exp_drop = 0;

    typedef struct {
        logic [BW-1:0] h;
        logic [7:0]    d;
        int            cyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    int            d0;
    int            lat;
    logic [BW-1:0] snap2;
    logic          db_cur, vs_cur;

    bar_height_loader #(.NUM_BARS(NB), .HEIGHT_W(HW), .ADDR_W(AW),
                        .RD_LATENCY(LAT), .COMMIT_ON_VSYNC(1)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .data_back(data_back), .VGA_VS(VGA_VS),
        .rd_q(rd_q), .rd_addr(rd_addr), .ready(ready), .heights(heights),
        .frame_updated(frame_updated), .drop_count(drop_count));

    bar_height_loader #(.NUM_BARS(NB), .HEIGHT_W(HW), .ADDR_W(AW),
                        .RD_LATENCY(LAT), .COMMIT_ON_VSYNC(0)) dut_imm (
        .CLOCK_50(CLOCK_50), .reset(reset), .data_back(data_back2), .VGA_VS(VGA_VS2),
        .rd_q(rd_q2), .rd_addr(rd_addr2), .ready(ready2), .heights(heights2),
        .frame_updated(frame_updated2), .drop_count(drop_count2));

    initial forever #10 CLOCK_50 = ~CLOCK_50;

    initial forever begin
        @(posedge CLOCK_50);
        cycle_count++;
    end

    // RAM read path: data for an address appears LAT cycles after it is presented
    always @(posedge CLOCK_50) begin
        apipe[0]  <= rd_addr;
        apipe2[0] <= rd_addr2;
        for (int i = 1; i < LAT; i++) begin
            apipe[i]  <= apipe[i-1];
            apipe2[i] <= apipe2[i-1];
        end
    end
    assign rd_q  = ram[apipe[LAT-1]];
    assign rd_q2 = ram[apipe2[LAT-1]];

    function automatic logic [BW-1:0] pack_ram();
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) r[i*HW +: HW] = ram[i];
        return r;
    endfunction

    task automatic randomize_ram();
        for (int i = 0; i < NB; i++) ram[i] = HW'($urandom_range(63));
    endtask

    task automatic checkOutput(input string name, input logic [BW-1:0] actual,
                               input logic [BW-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, expected, cycle_count);
        end
    endtask

    // Drive one cycle of inputs and advance the reference model for that cycle
    task automatic applyStimulus(input logic db, input logic vs, input logic rst, input logic db2);
        logic req, fb, accepted;
        @(posedge CLOCK_50);
        #1;
        reset      = rst;
        data_back  = db;
        VGA_VS     = vs;
        data_back2 = db2;
        if (rst) begin
            mdl_busy = 1'b0;
            sb_q.delete();
            exp_drop = 0;
            prev_db  = 1'b1;
            prev_vs  = 1'b0;
        end else begin
            req      = db && !prev_db;
            fb       = !vs && prev_vs;
            accepted = 1'b0;
            if (req) begin
                if (mdl_busy) begin
                    if (exp_drop < 255) exp_drop++;
                end else begin
                    mdl_busy  = 1'b1;
                    mdl_start = cycle_count;
                    mdl_snap  = pack_ram();
                    accepted  = 1'b1;
                end
            end
            if (mdl_busy && !accepted && fb && (cycle_count >= mdl_start + COMMIT_DELAY)) begin
                sb_q.push_back('{mdl_snap, 8'(exp_drop), cycle_count + 1});
                mdl_busy = 1'b0;
            end
            prev_db = db;
            prev_vs = vs;
        end
    endtask

    // Monitor: every visible-bank update must match the oldest expected commit
    initial forever begin
        @(negedge CLOCK_50);
        if (frame_updated === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_frame_updated: got pulse at cycle %0d, expected none",
                         cycle_count);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("commit_heights", heights, mon_e.h);
                checkOutput("commit_drops", BW'(drop_count), BW'(mon_e.d));
                checkOutput("commit_cycle", BW'(cycle_count), BW'(mon_e.cyc));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle_count);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset hold with request high and vsync toggling
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_heights", heights, '0);
        checkOutput("rst_ready", BW'(ready), BW'(1));
        checkOutput("rst_drops", BW'(drop_count), BW'(0));
        checkOutput("rst_rd_addr", BW'(rd_addr), BW'(0));
        checkOutput("rst_frame_updated", BW'(frame_updated), BW'(0));
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_no_load_ready", BW'(ready), BW'(1));

        // Basic load with ramp data, commit at a frame boundary 40 cycles later
        for (int i = 0; i < NB; i++) ram[i] = HW'(i + 10);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < NB; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput("sweep_rd_addr", BW'(rd_addr), BW'(k));
            checkOutput("sweep_ready", BW'(ready), BW'(0));
        end
        checkOutput("heights_before_commit", heights, '0);
        repeat (19) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("basic_ready_after", BW'(ready), BW'(1));
        checkOutput("basic_bar0", BW'(heights[HW-1:0]), BW'(10));
        checkOutput("basic_bar19", BW'(heights[BW-1 -: HW]), BW'(29));
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("basic_single_pulse", BW'(frame_updated), BW'(0));

        // Immediate-commit instance: latency from request to update
        randomize_ram();
        snap2 = pack_ram();
        lat = -1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 40; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
            if (i == 10) checkOutput("imm_ready_busy", BW'(ready2), BW'(0));
            if ((frame_updated2 === 1'b1) && (lat < 0)) lat = i;
        end
        checkOutput("imm_latency", BW'(lat), BW'(COMMIT_DELAY));
        checkOutput("imm_heights", heights2, snap2);
        checkOutput("imm_drops", BW'(drop_count2), BW'(0));
        checkOutput("imm_ready_after", BW'(ready2), BW'(1));

        // Overlapping requests: one during the sweep, three while pending
        d0 = exp_drop;
        randomize_ram();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int off = 1; off <= 40; off++)
            applyStimulus((off == 4 || off == 27 || off == 29 || off == 31) ? 1'b0 : 1'b1,
                          (off == 35) ? 1'b0 : 1'b1, 1'b0, 1'b0);
        checkOutput("overlap_drops", BW'(drop_count), BW'(d0 + 4));

        // Request and frame boundary in the same pending cycle
        d0 = exp_drop;
        randomize_ram();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int off = 1; off <= 31; off++)
            applyStimulus((off == 29) ? 1'b0 : 1'b1, (off == 30) ? 1'b0 : 1'b1, 1'b0, 1'b0);
        checkOutput("simul_ready", BW'(ready), BW'(1));
        checkOutput("simul_drops", BW'(drop_count), BW'(d0 + 1));
        randomize_ram();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("simul_reload_ready", BW'(ready), BW'(0));
        repeat (28) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of the sweep, then a clean reload
        randomize_ram();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (7) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("abort_rd_addr_before", BW'(rd_addr), BW'(7));
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("abort_ready", BW'(ready), BW'(1));
        checkOutput("abort_heights", heights, '0);
        checkOutput("abort_rd_addr", BW'(rd_addr), BW'(0));
        checkOutput("abort_drops", BW'(drop_count), BW'(0));
        randomize_ram();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (30) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

        // Random requests and frame boundaries
        db_cur = 1'b1;
        vs_cur = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15) == 0) db_cur = ~db_cur;
            if ($urandom_range(9) == 0)  vs_cur = ~vs_cur;
            if (!mdl_busy && db_cur && !prev_db) randomize_ram();
            applyStimulus(db_cur, vs_cur, 1'b0, 1'b0);
        end
        repeat (40) applyStimulus(db_cur, 1'b1, 1'b0, 1'b0);
        applyStimulus(db_cur, 1'b0, 1'b0, 1'b0);
        repeat (5) applyStimulus(db_cur, 1'b1, 1'b0, 1'b0);

        // Drop counter saturation while a load waits for a frame boundary
        randomize_ram();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("drop_saturate", BW'(drop_count), BW'(255));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

        checkOutput("scoreboard_empty", BW'(sb_q.size()), BW'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
